// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker and the stimulus-side benches.
// Holds the FSM encoding, gate select codes and the golden gate function.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    REPORT = 2'd3
  } chk_state_t;

  localparam logic GATE_NOR   = 1'b0;
  localparam logic GATE_NAND  = 1'b1;
  localparam int   GATE_MAX_W = 32;

  // Operands are zero-extended by callers; only the low W bits are meaningful.
  function automatic logic [GATE_MAX_W-1:0] gate_golden(input logic [GATE_MAX_W-1:0] a,
                                                        input logic [GATE_MAX_W-1:0] b,
                                                        input logic sel);
    return (sel == GATE_NAND) ? ~(a & b) : ~(a | b);
  endfunction

endpackage

// File: rtl/gate_response_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear and reset take priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/gate_response_checker.sv
// Applies one stimulus pair per handshake, waits a settle window, then checks
// the gate output against the NOR/NAND golden value and keeps result statistics.
//
//   state  | meaning
//   IDLE   | stim_ready high, waiting for a stimulus pair
//   SETTLE | down-counting the settle window after accept
//   SAMPLE | comparing dut_out against the golden value
//   REPORT | res_valid pulse, counters and first-fail record update
module gate_response_checker #(
  parameter int W      = 1,
  parameter int SETTLE = 2,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          stim_valid,
  output logic          stim_ready,
  input  logic [W-1:0]  stim_a,
  input  logic [W-1:0]  stim_b,
  input  logic          gate_sel,
  input  logic [W-1:0]  dut_out,
  output logic          res_valid,
  output logic          res_pass,
  output logic [CW-1:0] vec_count,
  output logic [CW-1:0] err_count,
  output logic          first_fail_vld,
  output logic [W-1:0]  first_fail_a,
  output logic [W-1:0]  first_fail_b
);
  import gate_chk_pkg::*;

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = (SETTLE > 0) ? SCW'(SETTLE - 1) : '0;
  localparam logic [GATE_MAX_W-1:0] CMP_MASK = {GATE_MAX_W{1'b1}} >> (GATE_MAX_W - W);

  chk_state_t          state;
  chk_state_t          next_state;
  logic [SCW-1:0]      cnt;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                sel_q;
  logic                pass_q;
  logic                accept;
  logic                match;
  logic                report_fail;
  logic [GATE_MAX_W-1:0] golden;

  assign accept      = stim_valid && stim_ready;
  assign golden      = gate_golden(GATE_MAX_W'(a_q), GATE_MAX_W'(b_q), sel_q);
  // Compare at full width with a mask so W < 32 leaves no dangling golden bits.
  assign match       = ((golden ^ GATE_MAX_W'(dut_out)) & CMP_MASK) == '0;
  assign report_fail = (state == REPORT) && !pass_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:                 if (accept) next_state = (SETTLE == 0) ? SAMPLE : gate_chk_pkg::SETTLE;
      gate_chk_pkg::SETTLE: if (cnt == '0) next_state = SAMPLE;
      SAMPLE:               next_state = REPORT;
      REPORT:               next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  always_comb begin
    stim_ready = (state == IDLE);
    res_valid  = (state == REPORT);
    res_pass   = pass_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= GATE_NOR;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= stim_a;
            b_q   <= stim_b;
            sel_q <= gate_sel;
            cnt   <= SETTLE_LOAD;
          end
        end
        gate_chk_pkg::SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        SAMPLE:               pass_q <= match;
        default:              ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_fail_vld <= 1'b0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
    end else if (report_fail && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_a   <= a_q;
      first_fail_b   <= b_q;
    end
  end

  sat_counter #(.WIDTH(CW)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .inc (state == REPORT),
    .clr (clear),
    .q   (vec_count)
  );

  sat_counter #(.WIDTH(CW)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (report_fail),
    .clr (clear),
    .q   (err_count)
  );

endmodule
